requant_relu: RTL
=================

Name: requant_relu

Overview:
- Streaming post-processing stage between the convolution accumulator and the 2x2 maxpool engine.
- Converts each wide signed accumulator value to a signed 8-bit activation: bias add, fixed-point scale, rounding shift, saturation, optional ReLU.
- Emits one int8 pixel per accepted input, in raster order, with a fixed latency of 3 cycles and no backpressure.
- Counts pixels per feature map and flags the last pixel of each frame.

Parameters:
- ACC_WIDTH, 32, width of signed accumulator input and of bias.
- MULT_WIDTH, 16, width of unsigned requant multiplier.
- SHIFT_WIDTH, 5, width of right-shift amount.
- MAP_WIDTH, 28, input map side; frame = MAP_WIDTH*MAP_WIDTH pixels.
- RELU_EN, 1, 1 = clamp negatives to 0; 0 = pass signed result.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- cfg_load  in  1  latch cfg_* this cycle (honoured only when idle).
- cfg_bias  in  ACC_WIDTH  signed bias.
- cfg_mult  in  MULT_WIDTH  unsigned multiplier.
- cfg_shift  in  SHIFT_WIDTH  arithmetic right-shift amount.
- valid_in  in  1  acc_in valid this cycle.
- acc_in  in  ACC_WIDTH  signed accumulator value.
- valid_out  out  1  pixel_out valid (single-cycle per pixel).
- pixel_out  out  8  signed int8 activation.
- frame_done  out  1  one-cycle pulse coincident with valid_out of the frame's last pixel.
- busy  out  1  frame in progress or pipeline non-empty.
- cfg_err  out  1  one-cycle pulse when cfg_load is rejected.

Behaviour:
- Reset (async assert, released synchronously to clk): valid_out, pixel_out, frame_done, busy, cfg_err = 0; pipeline valids cleared; pixel counter = 0; config bias = 0, mult = 1, shift = 0.
- Config: if cfg_load and not busy, latch bias/mult/shift at the edge; the new config applies from the next accepted pixel. If cfg_load while busy, ignore and pulse cfg_err the next cycle. cfg_load concurrent with the first valid_in of a frame (busy = 0) is accepted, and that pixel uses the OLD config.
- Pipeline, 3 registered stages, each carrying valid + last tag:
  - S1: sum = acc_in + bias, sign-extended to ACC_WIDTH+1 bits (no overflow).
  - S2: prod = sum * {0, mult}, signed, ACC_WIDTH+MULT_WIDTH+2 bits (exact).
  - S3: if shift > 0, r = (prod + (1 << (shift-1))) >>> shift; else r = prod. Rounding is half toward +inf. Saturate r to [-128, 127]. If RELU_EN, negative results become 0. Register the result into pixel_out.
- Latency: valid_in at cycle N produces valid_out at cycle N+3. Bubbles are preserved exactly and the pipeline never stalls.
- pixel_out holds its last value when valid_out = 0.
- Counter:
  - Increments on valid_in.
  - At FRAME-1 it wraps to 0 and tags that pixel as last.
  - The tag travels with the pixel; frame_done = valid_out of the tagged pixel.
- busy = (counter != 0) or any stage valid.
- Back-to-back frames: valid_in may continue immediately after the last pixel; the counter restarts at 0 with no gap required.
- Reset mid-frame: everything in flight is discarded, no valid_out follows, and the counter restarts.
- Counter width: $clog2(MAP_WIDTH*MAP_WIDTH).

Decomposition:
- Shared package:
  - act_t (signed 8-bit).
  - ACT_MAX = 127, ACT_MIN = -128.
  - A function sat_to_act(wide value) returning act_t. The maxpool engine and later stages reuse act_t.
- One natural sub-module, requant_round_sat: the combinational S3 datapath (round, shift, saturate, ReLU). It is unit-testable in isolation; pipeline registers stay in the top.

Test Plan:
- Identity and bias: reset config, then bias = 10 via cfg_load; acc_in = 5 -> pixel_out = 15 exactly 3 cycles after valid_in; acc_in = 200 -> 127 (saturated).
- Rounding: bias = 0, mult = 3, shift = 2; acc 5 -> 4 ((15+2)>>>2); acc 1 -> 1 ((3+2)>>>2); shift = 0, mult = 1, acc -300 -> 0 with RELU_EN = 1, -128 with RELU_EN = 0.
- Negative rounding, RELU_EN = 0: mult = 1, shift = 2; acc -6 -> -1; acc -7 -> -2; acc -2 -> 0.
- Frame: MAP_WIDTH = 4; 16 valid_in with random gaps:
  - Required response: 16 valid_out, each 3 cycles after its input, gap pattern identical.
  - frame_done only on the 16th.
  - busy falls the cycle after.
  - A 17th pixel starts a new frame.
- Config guarding: cfg_load mid-frame -> cfg_err pulses, outputs unchanged; cfg_load after busy = 0 -> new scale visible on the next pixel.
- Async reset asserted mid-frame between clock edges: outputs go to 0 immediately, no valid_out after release, next frame_done after a full 16 fresh pixels.

Source files
------------

// File: rtl/requant_relu_pkg.sv
// Shared activation type and saturation helper for requant_relu and the
// downstream int8 stages (maxpool and later).
package requant_relu_pkg;

  typedef logic signed [7:0] act_t;

  localparam act_t ACT_MAX = act_t'(8'h7f);
  localparam act_t ACT_MIN = act_t'(8'h80);

  // Widest signed value sat_to_act accepts; callers sign-extend into it.
  localparam int SAT_W = 64;

  function automatic act_t sat_to_act(input logic signed [SAT_W-1:0] v);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    act_t                    res;
    hi = ACT_MAX;
    lo = ACT_MIN;
    if (v > hi) begin
      res = ACT_MAX;
    end else if (v < lo) begin
      res = ACT_MIN;
    end else begin
      res = act_t'(v[7:0]);
    end
    return res;
  endfunction

endpackage

// File: rtl/requant_round_sat.sv
// Combinational output stage: round-half-up arithmetic right shift,
// saturation to int8 and optional ReLU clamp.
module requant_round_sat
  import requant_relu_pkg::*;
#(
  parameter int PROD_W      = 50,
  parameter int SHIFT_WIDTH = 5,
  parameter int RELU_EN     = 1
) (
  input  logic signed [PROD_W-1:0]      prod_i,
  input  logic        [SHIFT_WIDTH-1:0] shift_i,
  output act_t                          act_o
);

  // One guard bit so adding the rounding constant can never wrap.
  localparam int RW = PROD_W + 1;

  logic signed [RW-1:0]    ext;
  logic signed [RW-1:0]    half;
  logic signed [RW-1:0]    rounded;
  logic signed [SAT_W-1:0] wide;
  act_t                    sat;

  always_comb begin
    ext  = {prod_i[PROD_W-1], prod_i};
    half = '0;
    if (shift_i != '0) begin
      half = RW'(1) << (shift_i - SHIFT_WIDTH'(1));
    end
    rounded = (ext + half) >>> shift_i;
    wide    = SAT_W'(rounded);
    sat     = sat_to_act(wide);
    act_o   = ((RELU_EN != 0) && (sat < 0)) ? '0 : sat;
  end

endmodule

// File: rtl/requant_relu.sv
// Requantisation stage: 3-cycle fixed-latency pipeline turning wide signed
// accumulator values into int8 activations, with per-frame last-pixel tagging.
module requant_relu
  import requant_relu_pkg::*;
#(
  parameter int ACC_WIDTH   = 32,
  parameter int MULT_WIDTH  = 16,
  parameter int SHIFT_WIDTH = 5,
  parameter int MAP_WIDTH   = 28,
  parameter int RELU_EN     = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cfg_load,
  input  logic signed [ACC_WIDTH-1:0] cfg_bias,
  input  logic [MULT_WIDTH-1:0]       cfg_mult,
  input  logic [SHIFT_WIDTH-1:0]      cfg_shift,
  input  logic                        valid_in,
  input  logic signed [ACC_WIDTH-1:0] acc_in,
  output logic                        valid_out,
  output act_t                        pixel_out,
  output logic                        frame_done,
  output logic                        busy,
  output logic                        cfg_err
);

  localparam int FRAME  = MAP_WIDTH * MAP_WIDTH;
  localparam int CNT_W  = (FRAME > 1) ? $clog2(FRAME) : 1;
  localparam int SUM_W  = ACC_WIDTH + 1;
  localparam int PROD_W = ACC_WIDTH + MULT_WIDTH + 2;

  // Stream interface is valid-only with no ready: every edge with valid_in
  // high accepts a sample, and valid_out is a one-cycle strobe exactly three
  // edges later. Bubbles pass through unchanged; nothing ever stalls.

  logic signed [ACC_WIDTH-1:0] bias_q;
  logic [MULT_WIDTH-1:0]       mult_q;
  logic [SHIFT_WIDTH-1:0]      shift_q;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic                        last_d;
  logic                        busy_d;
  logic                        cfg_ok;
  logic                        cfg_err_q;

  logic                        v1_q, l1_q;
  logic signed [SUM_W-1:0]     sum_q, sum_d;
  logic [MULT_WIDTH-1:0]       m1_q;
  logic [SHIFT_WIDTH-1:0]      sh1_q;

  logic                        v2_q, l2_q;
  logic signed [PROD_W-1:0]    prod_q, prod_d;
  logic [SHIFT_WIDTH-1:0]      sh2_q;

  logic                        valid_out_q, frame_done_q;
  act_t                        pixel_q;
  act_t                        act_d;

  always_comb begin
    last_d = (cnt_q == CNT_W'(FRAME - 1));
    cnt_d  = cnt_q;
    if (valid_in) begin
      cnt_d = last_d ? '0 : cnt_q + CNT_W'(1);
    end
    busy_d = (cnt_q != '0) | v1_q | v2_q | valid_out_q;
    cfg_ok = cfg_load & ~busy_d;
    sum_d  = {acc_in[ACC_WIDTH-1], acc_in} + {bias_q[ACC_WIDTH-1], bias_q};
    prod_d = PROD_W'(sum_q) * PROD_W'(signed'({1'b0, m1_q}));
  end

  requant_round_sat #(
    .PROD_W      (PROD_W),
    .SHIFT_WIDTH (SHIFT_WIDTH),
    .RELU_EN     (RELU_EN)
  ) u_round_sat (
    .prod_i  (prod_q),
    .shift_i (sh2_q),
    .act_o   (act_d)
  );

  // Scale and shift ride along with each pixel, so a config latched on the
  // same edge as a frame's first pixel only affects the pixels after it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bias_q       <= '0;
      mult_q       <= MULT_WIDTH'(1);
      shift_q      <= '0;
      cnt_q        <= '0;
      cfg_err_q    <= 1'b0;
      v1_q         <= 1'b0;
      l1_q         <= 1'b0;
      sum_q        <= '0;
      m1_q         <= '0;
      sh1_q        <= '0;
      v2_q         <= 1'b0;
      l2_q         <= 1'b0;
      prod_q       <= '0;
      sh2_q        <= '0;
      valid_out_q  <= 1'b0;
      frame_done_q <= 1'b0;
      pixel_q      <= '0;
    end else begin
      if (cfg_ok) begin
        bias_q  <= cfg_bias;
        mult_q  <= cfg_mult;
        shift_q <= cfg_shift;
      end
      cfg_err_q <= cfg_load & busy_d;
      cnt_q     <= cnt_d;

      v1_q <= valid_in;
      l1_q <= valid_in & last_d;
      if (valid_in) begin
        sum_q <= sum_d;
        m1_q  <= mult_q;
        sh1_q <= shift_q;
      end

      v2_q <= v1_q;
      l2_q <= l1_q;
      if (v1_q) begin
        prod_q <= prod_d;
        sh2_q  <= sh1_q;
      end

      valid_out_q  <= v2_q;
      frame_done_q <= v2_q & l2_q;
      if (v2_q) begin
        pixel_q <= act_d;
      end
    end
  end

  assign valid_out  = valid_out_q;
  assign pixel_out  = pixel_q;
  assign frame_done = frame_done_q;
  assign busy       = busy_d;
  assign cfg_err    = cfg_err_q;

endmodule
